// File: rtl/drac_pkg.sv
// Shared core definitions. This slice carries the multiplier latency constants
// and the request type used by the multiplier issue scheduler.
package drac_pkg;

    localparam int unsigned MUL_LAT_32  = 1;
    localparam int unsigned MUL_LAT_64  = 2;
    localparam int unsigned MUL_REQ_NUM = 2;

    typedef struct packed {
        logic valid;
        logic op32;
    } mul_req_t;

endpackage

// File: rtl/mul_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from an eligible vector; the pointer
// moves to the other requester after every grant and holds otherwise.
module mul_rr_arb
    import drac_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [MUL_REQ_NUM-1:0] elig_i,
    output logic [MUL_REQ_NUM-1:0] gnt_o
);

    logic rr_ptr_q;

    always_comb begin
        gnt_o = '0;
        if (&elig_i) begin
            gnt_o[rr_ptr_q] = 1'b1;
        end else begin
            gnt_o = elig_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_ptr_q <= 1'b0;
        end else if (|gnt_o) begin
            rr_ptr_q <= ~gnt_o[1];
        end
    end

endmodule

// File: rtl/mul_issue_sched.sv
// Multiplier issue scheduler: round-robin issue, 64-bit/word writeback collision
// avoidance, in-flight tracking and flush. Optional perf counters: MUL_SCHED_PERF_EN.
module mul_issue_sched
    import drac_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic [MUL_REQ_NUM-1:0] req_valid_i,
    input  logic [MUL_REQ_NUM-1:0] req_op32_i,
    output logic [MUL_REQ_NUM-1:0] req_ready_o,
    output logic                   issue_valid_o,
    output logic                   issue_src_o,
    output logic                   issue_op32_o,
    output logic                   busy_o,
    output logic                   idle_o,
    output logic [31:0]            perf_grant_cnt_o,
    output logic [31:0]            perf_block_cnt_o
);

    mul_req_t [MUL_REQ_NUM-1:0] req;
    logic     [MUL_REQ_NUM-1:0] elig;
    logic     [MUL_REQ_NUM-1:0] gnt;
    logic                       pend64_q;
    logic                       op32_q;
    logic     [MUL_LAT_64-1:0]  occ_q;

    // A word op issued right after a 64-bit op would land on the same writeback cycle.
    always_comb begin
        for (int i = 0; i < MUL_REQ_NUM; i++) begin
            req[i].valid = req_valid_i[i];
            req[i].op32  = req_op32_i[i];
            elig[i]      = req[i].valid & ~(req[i].op32 & pend64_q) & ~flush_i & rstn_i;
        end
    end

    mul_rr_arb u_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .elig_i (elig),
        .gnt_o  (gnt)
    );

    assign req_ready_o   = gnt;
    assign issue_valid_o = |gnt;
    assign issue_src_o   = gnt[1];
    assign issue_op32_o  = |(gnt & req_op32_i);
    assign busy_o        = |occ_q;
    assign idle_o        = ~busy_o & ~issue_valid_o;

    // Stage boundary: grant -> in-flight tracking
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend64_q <= 1'b0;
            op32_q   <= 1'b0;
            occ_q    <= '0;
        end else if (flush_i) begin
            pend64_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            pend64_q <= issue_valid_o & ~issue_op32_o;
            occ_q    <= {occ_q[0] & ~op32_q, issue_valid_o};
            if (issue_valid_o) begin
                op32_q <= issue_op32_o;
            end
        end
    end

`ifdef MUL_SCHED_PERF_EN
    logic [31:0] grant_cnt_q;
    logic [31:0] block_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            grant_cnt_q <= '0;
            block_cnt_q <= '0;
        end else begin
            if (issue_valid_o) begin
                grant_cnt_q <= sat_inc(grant_cnt_q);
            end
            if (|req_valid_i & ~issue_valid_o & ~flush_i) begin
                block_cnt_q <= sat_inc(block_cnt_q);
            end
        end
    end

    assign perf_grant_cnt_o = grant_cnt_q;
    assign perf_block_cnt_o = block_cnt_q;
`else
    assign perf_grant_cnt_o = '0;
    assign perf_block_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mul_issue_sched.sv
// Directed bench for mul_issue_sched: reset, fairness, collision blocking,
// mixed widths, flush and drain timing.
module tb_mul_issue_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_op32;
    logic [1:0]  req_ready;
    logic        issue_valid;
    logic        issue_src;
    logic        issue_op32;
    logic        busy;
    logic        idle;
    logic [31:0] perf_grant;
    logic [31:0] perf_block;

    int n_checks = 0;
    int n_errors = 0;
    int grant_exp = 0;
    int block_exp = 0;

`ifdef MUL_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    mul_issue_sched dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_op32_i       (req_op32),
        .req_ready_o      (req_ready),
        .issue_valid_o    (issue_valid),
        .issue_src_o      (issue_src),
        .issue_op32_o     (issue_op32),
        .busy_o           (busy),
        .idle_o           (idle),
        .perf_grant_cnt_o (perf_grant),
        .perf_block_cnt_o (perf_block)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge and let combinational outputs settle.
    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic f);
        req_valid = v;
        req_op32  = w;
        flush     = f;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, "_grant_cnt"}, perf_grant, PERF ? 32'(grant_exp) : 32'd0);
        chk({tag, "_block_cnt"}, perf_block, PERF ? 32'(block_exp) : 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        drive(2'b00, 2'b00, 1'b0);
        repeat (3) cycle();
        rstn = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(issue_valid), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk_perf("rst");

        // Fairness: both requesters 64-bit every cycle
        drive(2'b11, 2'b00, 1'b0);
        chk("fair0_ready", 32'(req_ready), 32'h1);
        chk("fair0_src", 32'(issue_src), 32'h0);
        cycle();
        chk("fair1_ready", 32'(req_ready), 32'h2);
        chk("fair1_src", 32'(issue_src), 32'h1);
        cycle();
        chk("fair2_ready", 32'(req_ready), 32'h1);
        cycle();
        chk("fair3_ready", 32'(req_ready), 32'h2);
        chk("fair3_op32", 32'(issue_op32), 32'h0);
        grant_exp += 4;
        cycle();
        drive(2'b00, 2'b00, 1'b0);
        chk_perf("fair");
        // Drain after a 64-bit grant: busy at t+1, t+2; idle at t+3
        chk("drain64_t1_busy", 32'(busy), 32'h1);
        chk("drain64_t1_idle", 32'(idle), 32'h0);
        cycle();
        chk("drain64_t2_busy", 32'(busy), 32'h1);
        cycle();
        chk("drain64_t3_idle", 32'(idle), 32'h1);
        chk("drain64_t3_busy", 32'(busy), 32'h0);

        // Collision: 64-bit on req0, then word op on req1
        drive(2'b01, 2'b00, 1'b0);
        chk("coll_t0_ready", 32'(req_ready), 32'h1);
        cycle();
        drive(2'b10, 2'b10, 1'b0);
        chk("coll_t1_ready", 32'(req_ready), 32'h0);
        chk("coll_t1_valid", 32'(issue_valid), 32'h0);
        cycle();
        chk("coll_t2_ready", 32'(req_ready), 32'h2);
        chk("coll_t2_op32", 32'(issue_op32), 32'h1);
        chk("coll_t2_src", 32'(issue_src), 32'h1);
        grant_exp += 2;
        block_exp += 1;
        cycle();
        drive(2'b00, 2'b00, 1'b0);
        chk_perf("coll");
        // Drain after a word-op grant: busy at t+1, idle at t+2
        chk("drain32_t1_busy", 32'(busy), 32'h1);
        cycle();
        chk("drain32_t2_idle", 32'(idle), 32'h1);

        // Mixed: 64-bit grant, then req0 word op competes with req1 64-bit
        drive(2'b01, 2'b00, 1'b0);
        chk("mix_t0_ready", 32'(req_ready), 32'h1);
        cycle();
        drive(2'b11, 2'b01, 1'b0);
        chk("mix_t1_ready", 32'(req_ready), 32'h2);
        chk("mix_t1_op32", 32'(issue_op32), 32'h0);
        cycle();
        drive(2'b01, 2'b01, 1'b0);
        chk("mix_t2_ready", 32'(req_ready), 32'h0);
        cycle();
        chk("mix_t3_ready", 32'(req_ready), 32'h1);
        chk("mix_t3_op32", 32'(issue_op32), 32'h1);
        grant_exp += 3;
        block_exp += 1;
        cycle();
        drive(2'b00, 2'b00, 1'b0);
        chk_perf("mix");
        repeat (3) cycle();

        // Flush: 64-bit grant, flush with requests pending, then word ops
        drive(2'b01, 2'b00, 1'b0);
        chk("fl_t0_ready", 32'(req_ready), 32'h1);
        cycle();
        drive(2'b11, 2'b00, 1'b1);
        chk("fl_t1_ready", 32'(req_ready), 32'h0);
        chk("fl_t1_valid", 32'(issue_valid), 32'h0);
        chk("fl_t1_busy", 32'(busy), 32'h1);
        cycle();
        drive(2'b11, 2'b11, 1'b0);
        chk("fl_t2_busy", 32'(busy), 32'h0);
        chk("fl_t2_ready", 32'(req_ready), 32'h2);
        chk("fl_t2_op32", 32'(issue_op32), 32'h1);
        grant_exp += 2;
        cycle();
        drive(2'b00, 2'b00, 1'b0);
        chk_perf("fl");
        cycle();
        chk("end_idle", 32'(idle), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mul_issue_sched.md
# mul_issue_sched

Issue scheduler for the two-stage integer multiplier in the execute stage. Arbitrates round-robin between two issue requesters, prevents writeback collisions between 64-bit ops (2-cycle latency) and 32-bit word ops (1-cycle latency) that share the multiplier's single result port, tracks in-flight multiplies for fence/drain, and clears all state on flush. Sits between the issue queues and the multiplier's instruction input.

## Interface
- Parameters: none. Latencies come from package constants.
- `clk_i`  in  1  core clock
- `rstn_i`  in  1  reset; synchronous, active-low
- `flush_i`  in  1  kill all in-flight and pending multiplies
- `req_valid_i`  in  2  per-requester request valid
- `req_op32_i`  in  2  per-requester word op (MULW); 0 = 64-bit op (MUL/MULH/MULHSU/MULHU)
- `req_ready_o`  out  2  one-hot grant; handshake completes when valid & ready
- `issue_valid_o`  out  1  instruction presented to multiplier this cycle
- `issue_src_o`  out  1  index of granted requester, which drives the multiplier mux
- `issue_op32_o`  out  1  op32 of granted request
- `busy_o`  out  1  at least one multiply in flight
- `idle_o`  out  1  ~busy_o & ~issue_valid_o; used by fence/CSR stall logic
- `perf_grant_cnt_o`  out  32  granted ops; present only with MUL_SCHED_PERF_EN
- `perf_block_cnt_o`  out  32  cycles with a valid request not granted; present only with MUL_SCHED_PERF_EN

## Operation
- **Collision rule.** A 64-bit op granted at cycle t writes back at t+2. A word op granted at t+1 would also write back at t+2.
  - `pend64_q` is set in the cycle after any 64-bit grant.
  - While `pend64_q`=1, requests with op32=1 are ineligible. 64-bit requests stay eligible.
- **Eligibility.** eligible[i] = req_valid_i[i] & ~(req_op32_i[i] & pend64_q) & ~flush_i.
- **Arbitration.**
  - Both requesters eligible: grant `rr_ptr_q`.
  - One eligible: grant that one.
  - After any grant, `rr_ptr_q` <= ~granted index. With no grant, the pointer holds.
- **Outputs.** At most one bit of `req_ready_o` is set. `issue_valid_o` = |req_ready_o. Ready is combinational from valid, so no bubble is inserted.
- **Requester rules.** A requester may drop or change its request in any cycle. An ungranted request has no side effects.
- **In-flight tracking.** Shift register `occ_q[1:0]`.
  - occ_q[0] <= issue_valid_o.
  - occ_q[1] <= occ_q[0] & ~op32_q, where op32_q is the registered op32 of the previous grant.
  - busy_o = |occ_q.
- **Flush.** During a flush cycle there are no grants. Next cycle: occ_q=0 and pend64_q=0. `rr_ptr_q` holds. Perf counters are not cleared.
- **Reset** (synchronous, rstn_i=0 at a clock edge):
  - rr_ptr_q=0, pend64_q=0, occ_q=0, op32_q=0, counters=0.
  - All outputs 0 except idle_o=1.
  - Reset mid-operation abandons in-flight ops with no completion indication.

## Timing
- Grant is combinational in the same cycle as the request.
- Result appears on the multiplier output at t+1 (op32) or t+2 (64-bit).
- Throughput is one op per cycle. A 64-bit op followed by a word op loses exactly one cycle.
- **flush_i with req_valid_i:** flush wins and no ready is asserted.
- **Back-to-back 64-bit ops:** allowed every cycle; `pend64_q` stays 1.
- **Alternating word/64-bit ops:** a word op never collides.
- **busy_o after the last grant:** falls 2 cycles later for op32, 3 cycles later for a 64-bit op (last grant at t, occ_q[1] at t+2, clear at t+3).

## Configuration
- **MUL_SCHED_PERF_EN defined:**
  - Two 32-bit saturating counters (hold at 0xFFFF_FFFF).
  - `perf_grant_cnt_o` increments per grant.
  - `perf_block_cnt_o` increments per cycle where |req_valid_i & ~issue_valid_o & ~flush_i.
- **Undefined:** both ports tie to 0 and no counter flops exist.

## Structure
- drac_pkg additions:
  - `MUL_LAT_32`=1, `MUL_LAT_64`=2
  - `typedef struct packed {logic valid; logic op32;} mul_req_t`
  - `MUL_REQ_NUM`=2
- One sub-module: `mul_rr_arb`, a 2-way round-robin arbiter with eligible vector in, one-hot grant out, and pointer update. The scheduler instantiates it once.

## Test plan
- **Reset/idle:** hold rstn_i=0 for 3 cycles, then release with no requests -> req_ready_o=00, idle_o=1, busy_o=0, counters=0.
- **Fairness:** both valid with op32=0 for 4 cycles -> ready sequence 01,10,01,10; perf_grant_cnt_o=4.
- **Collision block:** req0 64-bit at t, req1 op32 at t+1 (req0 idle) -> t+1 ready=00, t+2 ready=10; perf_block_cnt_o=1.
- **Mixed:** at t+1 after a 64-bit grant, req0 op32 and req1 64-bit -> req1 granted at t+1, req0 blocked until pend64_q clears.
- **Flush:** grant 64-bit at t, flush_i at t+1 with req valid -> ready=00 at t+1; busy_o=0 and pend64_q=0 at t+2; op32 is grantable at t+2.
- **Drain:** single op32 grant at t -> busy_o=1 at t+1, idle_o=1 at t+2. Single 64-bit grant at t -> busy_o=1 at t+1 and t+2, idle_o=1 at t+3.
